mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, operand width; even, >=4; result width 2*WIDTH.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a multiply; sampled only when accepting (REQ-011).
REQ-005 signed_mode  input  1  1 = two's-complement (MLS), 0 = unsigned (MUL); sampled with start.
REQ-006 abort  input  1  synchronous cancel of an in-flight multiply.
REQ-007 opa, opb  input  WIDTH each  multiplicand and multiplier; sampled with start.
REQ-008 busy  output  1  high in RUN and FIX.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result_lo, result_hi; flag_z, flag_n  output  WIDTH each; 1 each  product halves; zero and negative flags.

Function
REQ-011 States IDLE, RUN, FIX, DONE; start is accepted in IDLE or DONE when abort is low.
REQ-012 On accept at edge T: capture magnitudes |opa|, |opb| (raw values if unsigned); sign = opa[MSB]^opb[MSB] when signed, else 0; clear accumulator; count = 0; next state RUN.
REQ-013 RUN: each cycle, if multiplier LSB = 1, add multiplicand into accumulator upper half with carry; shift {carry, accumulator, multiplier} right one bit; count increments.
REQ-014 RUN lasts exactly WIDTH cycles (T+1..T+WIDTH); then FIX.
REQ-015 FIX (T+WIDTH+1): two's-complement negate the 2*WIDTH product if sign = 1; register it into result_hi/result_lo, flag_z = (product == 0), flag_n = result_hi[MSB].
REQ-016 DONE (T+WIDTH+2): done = 1 for exactly one cycle; busy = 0; next state IDLE unless a new start is accepted (back-to-back).
REQ-017 Latency: start to done = WIDTH+2 cycles (18 at WIDTH=16).
REQ-018 result_*, flag_* change only in FIX and hold until the next FIX.
REQ-019 start while busy is ignored, not queued.
REQ-020 abort in RUN or FIX: next state IDLE; no done; results and flags unchanged.
REQ-021 abort and start together in IDLE/DONE: abort wins; no accept.
REQ-022 Signed most-negative operand (0x8000) has magnitude 0x8000 as an unsigned WIDTH-bit value; no overflow; product is exact in 2*WIDTH bits.
REQ-023 Unsigned full-scale product (2^WIDTH-1)^2 is exact; the carry out of the accumulator add is retained through the shift.

Reset
REQ-024 rst_n low: state IDLE, busy 0, done 0, result_lo/hi 0, flag_z 0, flag_n 0, count 0, accumulator 0; applies immediately, including mid-RUN.
REQ-025 After rst_n rises, the first accept is possible at the first rising edge.

Structure
REQ-026 Shared package alu_pkg: state enumeration, WIDTH default, opcode constants MUL = 6'b100001 and MLS = 6'b100010.
REQ-027 One sub-module, mul_datapath: accumulator, multiplicand/multiplier registers, counter, negate logic.
REQ-028 The FSM and handshake reside in mul_sequencer.

Verification
REQ-029 Unsigned 0xFFFF x 0xFFFF, start at T -> done at T+18; hi = 0xFFFE, lo = 0x0001; flag_n = 1; flag_z = 0.
REQ-030 Signed 0xFFFF x 0x0002 -> hi = 0xFFFF, lo = 0xFFFE, flag_n = 1; signed 0x8000 x 0x8000 -> hi = 0x4000, lo = 0x0000.
REQ-031 0x1234 x 0x0000 (either mode) -> result 0, flag_z = 1, flag_n = 0.
REQ-032 Second start at T+3 while busy -> ignored; single done at T+18; start held high through DONE -> second op accepted, done at T+36.
REQ-033 abort at T+5 -> busy low at T+6; no done; results retain the prior product.
REQ-034 rst_n pulsed low at T+8 -> all outputs 0 asynchronously; no done; new op completes normally afterward.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state encoding, default width and opcodes for the multiply sequencer
package alu_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [5:0] OP_MUL = 6'b100001;
  localparam logic [5:0] OP_MLS = 6'b100010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_datapath.sv
// rtl/mul_datapath.sv - shift-add multiplier datapath: operand magnitudes, accumulator,
// step counter, sign fix-up and result/flag registers
module mul_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             last,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic               sign;
  logic [CW-1:0]      count;

  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] fixed;

  // The most-negative operand negates to itself, which is its correct unsigned magnitude.
  always_comb begin
    is_signed = (op == OP_MLS);
    mag_a     = (is_signed && opa[WIDTH-1]) ? ('0 - opa) : opa;
    mag_b     = (is_signed && opb[WIDTH-1]) ? ('0 - opb) : opb;
    sum       = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : '0)};
    prod      = {acc, mplier};
    fixed     = sign ? ('0 - prod) : prod;
    last      = (count == CW'(WIDTH - 1));
  end

  // The add carry becomes the new accumulator MSB, so a full-scale product stays exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      sign      <= 1'b0;
      count     <= '0;
      result_lo <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
    end else begin
      if (load) begin
        mcand  <= mag_a;
        mplier <= mag_b;
        acc    <= '0;
        sign   <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        count  <= '0;
      end else if (step) begin
        acc    <= sum[WIDTH:1];
        mplier <= {sum[0], mplier[WIDTH-1:1]};
        count  <= count + CW'(1);
      end
      if (fix) begin
        result_hi <= fixed[2*WIDTH-1:WIDTH];
        result_lo <= fixed[WIDTH-1:0];
        flag_z    <= (prod == '0);
        flag_n    <= fixed[2*WIDTH-1];
      end
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - start/abort handshake and IDLE/RUN/FIX/DONE control around mul_datapath
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n
);

  state_t     state;
  state_t     next_state;
  logic       accept;
  logic       step;
  logic       fix;
  logic       last;
  logic [5:0] op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // abort beats start, and also cancels RUN/FIX before the result registers load.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    op         = signed_mode ? OP_MLS : OP_MUL;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          accept     = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort) begin
          next_state = ST_IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            next_state = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        busy = 1'b1;
        if (abort) begin
          next_state = ST_IDLE;
        end else begin
          fix        = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start && !abort) begin
          accept     = 1'b1;
          next_state = ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (step),
    .fix      (fix),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .last     (last),
    .result_lo(result_lo),
    .result_hi(result_hi),
    .flag_z   (flag_z),
    .flag_n   (flag_n)
  );

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - scoreboard bench for mul_sequencer at WIDTH=16
module tb_mul_sequencer;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         z;
    logic         n;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         flag_z;
  logic         flag_n;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_seen = 0;
  exp_t sb[$];
  exp_t last_exp;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_mode(signed_mode),
    .abort      (abort),
    .opa        (opa),
    .opb        (opb),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .flag_z     (flag_z),
    .flag_n     (flag_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 input int c);
    exp_t e;
    logic signed [2*W-1:0] ps;
    logic [2*W-1:0] p;
    if (s) begin
      ps = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      p  = ps;
    end else begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
    e.hi  = p[2*W-1:W];
    e.lo  = p[W-1:0];
    e.z   = (p == '0);
    e.n   = p[2*W-1];
    e.cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      check("busy_in_done", busy, 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("result_hi", result_hi, e.hi);
        check("result_lo", result_lo, e.lo);
        check("flag_z", flag_z, e.z);
        check("flag_n", flag_n, e.n);
        last_exp = e;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit push);
    @(negedge clk);
    start = 1'b1;
    opa = a;
    opb = b;
    signed_mode = s;
    if (push) sb.push_back(model(a, b, s, cyc + 18));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || busy || done); i++) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int c;
    int d0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lo", result_lo, 0);
    check("rst_hi", result_hi, 0);
    check("rst_flags", {flag_z, flag_n}, 0);
    rst_n = 1'b1;

    c = cyc + 1;
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    check("busy_run", busy, 1);
    drain();
    issue(16'hFFFF, 16'h0002, 1'b1, 1'b1);
    drain();
    issue(16'h8000, 16'h8000, 1'b1, 1'b1);
    drain();
    issue(16'h1234, 16'h0000, 1'b0, 1'b1);
    drain();
    issue(16'h1234, 16'h0000, 1'b1, 1'b1);
    drain();
    issue(16'h8000, 16'h7FFF, 1'b1, 1'b1);
    drain();
    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      issue(ra, rb, k[0], 1'b1);
      drain();
    end

    // start while busy is ignored
    d0 = done_seen;
    @(negedge clk);
    c = cyc;
    start = 1'b1; opa = 16'h0123; opb = 16'h0456; signed_mode = 1'b0;
    sb.push_back(model(16'h0123, 16'h0456, 1'b0, c + 18));
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c + 3);
    start = 1'b1; opa = 16'hAAAA; opb = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("ignored_start_dones", done_seen - d0, 1);

    // start held high through DONE: back-to-back
    d0 = done_seen;
    @(negedge clk);
    c = cyc;
    start = 1'b1; opa = 16'hFFFE; opb = 16'h0003; signed_mode = 1'b1;
    sb.push_back(model(16'hFFFE, 16'h0003, 1'b1, c + 18));
    @(negedge clk);
    opa = 16'h00FF; opb = 16'h0101; signed_mode = 1'b0;
    sb.push_back(model(16'h00FF, 16'h0101, 1'b0, c + 36));
    wait_cyc(c + 18);
    check("b2b_done_high", done, 1);
    @(negedge clk);
    start = 1'b0;
    drain();
    check("b2b_dones", done_seen - d0, 2);

    // abort mid-RUN
    d0 = done_seen;
    @(negedge clk);
    c = cyc;
    start = 1'b1; opa = 16'h7777; opb = 16'h3333;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c + 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    repeat (25) @(negedge clk);
    check("abort_no_done", done_seen - d0, 0);
    check("abort_hold_hi", result_hi, last_exp.hi);
    check("abort_hold_lo", result_lo, last_exp.lo);

    // abort and start together: abort wins
    start = 1'b1; abort = 1'b1; opa = 16'h0005; opb = 16'h0005;
    @(negedge clk);
    check("abort_start_busy", busy, 0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy2", busy, 0);

    // asynchronous reset mid-RUN, then accept on the first edge after release
    d0 = done_seen;
    @(negedge clk);
    c = cyc;
    start = 1'b1; opa = 16'h1111; opb = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c + 8);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_lo", result_lo, 0);
    check("arst_hi", result_hi, 0);
    check("arst_flags", {flag_z, flag_n}, 0);
    @(negedge clk);
    start = 1'b1; opa = 16'hFFFD; opb = 16'h0007; signed_mode = 1'b1;
    sb.push_back(model(16'hFFFD, 16'h0007, 1'b1, cyc + 18));
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_busy", busy, 1);
    drain();
    check("post_rst_dones", done_seen - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
